// File: rtl/marker_pixel_detector_pkg.sv
// Shared definitions for the marker pixel detector: pixel class encoding,
// luma threshold, per-class chroma windows and the frame-tracking states.
package marker_pixel_detector_pkg;

  // Marker classes 0-3 map directly onto the 2-bit color output; NONE is
  // the extra code that never gets reported.
  typedef enum logic [2:0] {
    CLS_0    = 3'd0,
    CLS_1    = 3'd1,
    CLS_2    = 3'd2,
    CLS_3    = 3'd3,
    CLS_NONE = 3'd4
  } pixel_class_t;

  localparam int NUM_CLASSES = 4;

  // Pixels darker than this never belong to a marker.
  localparam logic [7:0] Y_MIN = 8'd64;

  // Chroma windows, inclusive bounds, packed as {class3, class2, class1, class0}.
  //   class 0: high Cr, low Cb    class 1: low Cr, high Cb
  //   class 2: low Cr, low Cb     class 3: high Cr, high Cb
  localparam logic [NUM_CLASSES-1:0][7:0] CR_MIN = {8'd200, 8'd0,   8'd0,   8'd200};
  localparam logic [NUM_CLASSES-1:0][7:0] CR_MAX = {8'd255, 8'd60,  8'd60,  8'd255};
  localparam logic [NUM_CLASSES-1:0][7:0] CB_MIN = {8'd200, 8'd0,   8'd200, 8'd0};
  localparam logic [NUM_CLASSES-1:0][7:0] CB_MAX = {8'd255, 8'd60,  8'd255, 8'd60};

  // Frame tracking: nothing is reported until one complete vsync has been seen.
  typedef enum logic [1:0] {
    ST_SYNC_WAIT = 2'd0,
    ST_PRIME     = 2'd1,
    ST_ACTIVE    = 2'd2,
    ST_BLANK     = 2'd3
  } det_state_t;

  // Inclusive range test used for the chroma windows.
  function automatic logic in_window(input logic [7:0] v,
                                     input logic [7:0] lo,
                                     input logic [7:0] hi);
    return (v >= lo) && (v <= hi);
  endfunction

endpackage

// File: rtl/marker_pixel_detector_color_classifier.sv
// First pipeline stage: classifies a YCrCb sample into one of the marker
// classes and registers the result. Lowest matching class index wins.
module color_classifier
  import marker_pixel_detector_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic [7:0]   pixel_y,
  input  logic [7:0]   pixel_cr,
  input  logic [7:0]   pixel_cb,
  output pixel_class_t pixel_class
);

  logic [NUM_CLASSES-1:0] match;
  pixel_class_t           class_next;

  generate
    for (genvar gi = 0; gi < NUM_CLASSES; gi++) begin : g_window
      assign match[gi] = (pixel_y >= Y_MIN)
                      && in_window(pixel_cr, CR_MIN[gi], CR_MAX[gi])
                      && in_window(pixel_cb, CB_MIN[gi], CB_MAX[gi]);
    end
  endgenerate

  // Priority select: scan from the highest class down so the lowest match is kept.
  always_comb begin
    class_next = CLS_NONE;
    for (int k = NUM_CLASSES - 1; k >= 0; k--) begin
      if (match[k]) begin
        class_next = pixel_class_t'(k[2:0]);
      end
    end
  end

  // Register the class so stage 2 sees it one cycle after the sample.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pixel_class <= CLS_0;
    end else begin
      pixel_class <= class_next;
    end
  end

endmodule

// File: rtl/marker_pixel_detector.sv
// Marker pixel detector: tracks raster position, classifies each pixel and
// reports pixels that end a run of RUN_LEN same-class pixels, two cycles
// after the pixel arrives. frame_flag marks the blanking after a reported frame.
module marker_pixel_detector
  import marker_pixel_detector_pkg::*;
#(
  parameter int RUN_LEN  = 3,
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] pixel_y,
  input  logic [7:0] pixel_cr,
  input  logic [7:0] pixel_cb,
  input  logic       pixel_valid,
  input  logic       hsync,
  input  logic       vsync,
  output logic [1:0] color,
  output logic [9:0] interesting_x,
  output logic [8:0] interesting_y,
  output logic       interesting_flag,
  output logic       frame_flag
);

  localparam int               RUN_W   = $clog2(RUN_LEN + 1);
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(RUN_LEN);
  localparam logic [9:0]       H_LIM   = 10'(H_ACTIVE);
  localparam logic [8:0]       V_LIM   = 9'(V_ACTIVE);

  det_state_t       state_reg;
  logic             vsync_prev_reg;
  logic             frame_d1_reg;
  logic [9:0]       x_reg;
  logic [8:0]       y_reg;
  logic             s1_valid_reg;
  logic             s1_hsync_reg;
  logic [9:0]       s1_x_reg;
  logic [8:0]       s1_y_reg;
  pixel_class_t     s1_class;
  logic [RUN_W-1:0] run_reg;
  logic [RUN_W-1:0] run_next;
  pixel_class_t     prev_class_reg;
  logic             hit;
  logic             vsync_rise;
  logic             vsync_fall;
  logic             pixel_accept;

  assign vsync_rise = vsync & ~vsync_prev_reg;
  assign vsync_fall = ~vsync & vsync_prev_reg;

  // Only pixels inside the active window of a frame that began after a full
  // vsync are passed on; vsync high also drops the pixel on the rising edge.
  assign pixel_accept = pixel_valid && !vsync && (x_reg < H_LIM) && (y_reg < V_LIM)
                     && (state_reg == ST_ACTIVE);

  // Frame state machine with edge detect and the two-cycle delayed frame_flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg      <= ST_SYNC_WAIT;
      vsync_prev_reg <= 1'b0;
      frame_d1_reg   <= 1'b0;
      frame_flag     <= 1'b0;
    end else begin
      vsync_prev_reg <= vsync;
      frame_d1_reg   <= (state_reg == ST_BLANK);
      frame_flag     <= frame_d1_reg;
      case (state_reg)
        ST_SYNC_WAIT: if (vsync)      state_reg <= ST_PRIME;
        ST_PRIME:     if (vsync_fall) state_reg <= ST_ACTIVE;
        ST_ACTIVE:    if (vsync_rise) state_reg <= ST_BLANK;
        ST_BLANK:     if (vsync_fall) state_reg <= ST_ACTIVE;
        default:                      state_reg <= ST_SYNC_WAIT;
      endcase
    end
  end

  // Raster counters; a pixel coincident with hsync is tagged with the old x.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x_reg <= '0;
      y_reg <= '0;
    end else begin
      if (hsync) begin
        x_reg <= '0;
      end else if (pixel_valid && (x_reg < H_LIM)) begin
        x_reg <= x_reg + 10'd1;
      end
      if (vsync_fall) begin
        y_reg <= '0;
      end else if (hsync && (y_reg < V_LIM)) begin
        y_reg <= y_reg + 9'd1;
      end
    end
  end

  color_classifier u_classifier (
    .clk         (clk),
    .reset       (reset),
    .pixel_y     (pixel_y),
    .pixel_cr    (pixel_cr),
    .pixel_cb    (pixel_cb),
    .pixel_class (s1_class)
  );

  // Stage 1 side-band: validity, coordinates and line end travel with the class.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid_reg <= 1'b0;
      s1_hsync_reg <= 1'b0;
      s1_x_reg     <= '0;
      s1_y_reg     <= '0;
    end else begin
      s1_valid_reg <= pixel_accept;
      s1_hsync_reg <= hsync;
      s1_x_reg     <= x_reg;
      s1_y_reg     <= y_reg;
    end
  end

  // Run length including the stage-1 pixel; idle cycles leave the run untouched.
  always_comb begin
    run_next = run_reg;
    if (s1_valid_reg) begin
      if (s1_class == CLS_NONE) begin
        run_next = '0;
      end else if (s1_class != prev_class_reg) begin
        run_next = RUN_W'(1);
      end else if (run_reg >= RUN_MAX) begin
        run_next = RUN_MAX;
      end else begin
        run_next = run_reg + RUN_W'(1);
      end
    end
  end

  assign hit = s1_valid_reg && (s1_class != CLS_NONE) && (run_next == RUN_MAX);

  // Stage 2: report the pixel, then drop the run at line end so the
  // hsync-coincident pixel can still complete its own run.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      run_reg          <= '0;
      prev_class_reg   <= CLS_NONE;
      interesting_flag <= 1'b0;
      color            <= '0;
      interesting_x    <= '0;
      interesting_y    <= '0;
    end else begin
      interesting_flag <= hit;
      if (hit) begin
        color         <= 2'(s1_class);
        interesting_x <= s1_x_reg;
        interesting_y <= s1_y_reg;
      end
      if (s1_hsync_reg) begin
        run_reg        <= '0;
        prev_class_reg <= CLS_NONE;
      end else begin
        run_reg <= run_next;
        if (s1_valid_reg) begin
          prev_class_reg <= s1_class;
        end
      end
    end
  end

endmodule

// File: tb/tb_marker_pixel_detector.sv
// Directed bench for marker_pixel_detector. Each call of cyc() checks the
// outputs at a falling edge, then drives the next cycle's inputs; a pixel
// driven in call k shows up at the outputs in call k+2.
module tb_marker_pixel_detector;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] pixel_y = '0;
  logic [7:0] pixel_cr = '0;
  logic [7:0] pixel_cb = '0;
  logic       pixel_valid = 1'b0;
  logic       hsync = 1'b0;
  logic       vsync = 1'b0;
  logic [1:0] color;
  logic [9:0] interesting_x;
  logic [8:0] interesting_y;
  logic       interesting_flag;
  logic       frame_flag;

  int checks = 0;
  int errors = 0;

  localparam int C0 = 0, C1 = 1, C2 = 2, C3 = 3, CN = 4, CD = 5;

  marker_pixel_detector #(.RUN_LEN(3), .H_ACTIVE(640), .V_ACTIVE(480)) dut (
    .clk              (clk),
    .reset            (reset),
    .pixel_y          (pixel_y),
    .pixel_cr         (pixel_cr),
    .pixel_cb         (pixel_cb),
    .pixel_valid      (pixel_valid),
    .hsync            (hsync),
    .vsync            (vsync),
    .color            (color),
    .interesting_x    (interesting_x),
    .interesting_y    (interesting_y),
    .interesting_flag (interesting_flag),
    .frame_flag       (frame_flag)
  );

  always #5 clk = ~clk;

  // Sample values chosen on window edges: class 1 sits exactly at Y_MIN,
  // class 2 at Cr max / Cb min, class 3 at Cr max / Cb min of its window;
  // CD has class-1 chroma but luma one below Y_MIN.
  task automatic drive_pixel(input int cls);
    case (cls)
      C0:      begin pixel_y = 8'd128; pixel_cr = 8'd220; pixel_cb = 8'd30;  end
      C1:      begin pixel_y = 8'd64;  pixel_cr = 8'd30;  pixel_cb = 8'd220; end
      C2:      begin pixel_y = 8'd200; pixel_cr = 8'd60;  pixel_cb = 8'd0;   end
      C3:      begin pixel_y = 8'd128; pixel_cr = 8'd255; pixel_cb = 8'd200; end
      CD:      begin pixel_y = 8'd63;  pixel_cr = 8'd30;  pixel_cb = 8'd220; end
      default: begin pixel_y = 8'd128; pixel_cr = 8'd128; pixel_cb = 8'd128; end
    endcase
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic v, input int cls, input logic hs, input logic vs,
                     input logic ef, input int ex, input int ey, input int ec,
                     input logic eff, input string tag);
    @(negedge clk);
    chk({tag, ".flag"}, 32'(interesting_flag), 32'(ef));
    if (ef) begin
      chk({tag, ".x"}, 32'(interesting_x), ex);
      chk({tag, ".y"}, 32'(interesting_y), ey);
      chk({tag, ".color"}, 32'(color), ec);
      $display("[%0t] %s flag x=%0d y=%0d color=%0d", $time, tag,
               interesting_x, interesting_y, color);
    end
    chk({tag, ".frame_flag"}, 32'(frame_flag), 32'(eff));
    pixel_valid = v;
    drive_pixel(cls);
    hsync = hs;
    vsync = vs;
  endtask

  task automatic none_run(input int n, input string tag);
    for (int i = 0; i < n; i++) cyc(1, CN, 0, 0, 0, 0, 0, 0, 0, tag);
  endtask

  initial begin
    drive_pixel(CN);
    repeat (2) @(negedge clk);
    chk("reset.flag", 32'(interesting_flag), 0);
    chk("reset.frame_flag", 32'(frame_flag), 0);
    chk("reset.x", 32'(interesting_x), 0);
    chk("reset.y", 32'(interesting_y), 0);
    chk("reset.color", 32'(color), 0);
    reset = 1'b0;

    // Frame before any vsync: never reported.
    none_run(10, "syncwait");
    repeat (5) cyc(1, C2, 0, 0, 0, 0, 0, 0, 0, "syncwait_c2");
    repeat (2) cyc(0, CN, 0, 0, 0, 0, 0, 0, 0, "syncwait_idle");
    cyc(0, CN, 1, 0, 0, 0, 0, 0, 0, "syncwait_hs");
    repeat (3) cyc(0, CN, 0, 1, 0, 0, 0, 0, 0, "prime");
    cyc(0, CN, 0, 0, 0, 0, 0, 0, 0, "prime_fall");

    // Line y=0: class 2 at x=10..14 -> flags at 12,13,14.
    none_run(10, "l0_lead");
    cyc(1, C2, 0, 0, 0, 0,  0, 0, 0, "l0_x10");
    cyc(1, C2, 0, 0, 0, 0,  0, 0, 0, "l0_x11");
    cyc(1, C2, 0, 0, 0, 0,  0, 0, 0, "l0_x12");
    cyc(1, C2, 0, 0, 0, 0,  0, 0, 0, "l0_x13");
    cyc(1, C2, 0, 0, 1, 12, 0, 2, 0, "l0_x14");
    cyc(0, CN, 0, 0, 1, 13, 0, 2, 0, "l0_tail");
    cyc(0, CN, 1, 0, 1, 14, 0, 2, 0, "l0_hs");

    // Line y=1: 1,1,dark,1,1,1 -> one flag at x=5.
    cyc(1, C1, 0, 0, 0, 0, 0, 0, 0, "l1_x0");
    cyc(1, C1, 0, 0, 0, 0, 0, 0, 0, "l1_x1");
    cyc(1, CD, 0, 0, 0, 0, 0, 0, 0, "l1_x2");
    cyc(1, C1, 0, 0, 0, 0, 0, 0, 0, "l1_x3");
    cyc(1, C1, 0, 0, 0, 0, 0, 0, 0, "l1_x4");
    cyc(1, C1, 0, 0, 0, 0, 0, 0, 0, "l1_x5");
    cyc(0, CN, 0, 0, 0, 0, 0, 0, 0, "l1_tail");
    cyc(0, CN, 0, 0, 1, 5, 1, 1, 0, "l1_flag");
    cyc(0, CN, 1, 0, 0, 0, 0, 0, 0, "l1_hs");

    // Line y=2: class 0 pixels separated by 4 idle cycles; third one flagged.
    cyc(1, C0, 0, 0, 0, 0, 0, 0, 0, "l2_x0");
    repeat (4) cyc(0, CN, 0, 0, 0, 0, 0, 0, 0, "l2_gap");
    cyc(1, C0, 0, 0, 0, 0, 0, 0, 0, "l2_x1");
    repeat (4) cyc(0, CN, 0, 0, 0, 0, 0, 0, 0, "l2_gap");
    cyc(1, C0, 0, 0, 0, 0, 0, 0, 0, "l2_x2");
    cyc(0, CN, 0, 0, 0, 0, 0, 0, 0, "l2_tail");
    cyc(0, CN, 0, 0, 1, 2, 2, 0, 0, "l2_flag");
    cyc(0, CN, 1, 0, 0, 0, 0, 0, 0, "l2_hs");

    // Line y=3: class 3 at x=637..639, hsync on x=639; next line restarts the run.
    none_run(637, "l3_lead");
    cyc(1, C3, 0, 0, 0, 0,   0, 0, 0, "l3_x637");
    cyc(1, C3, 0, 0, 0, 0,   0, 0, 0, "l3_x638");
    cyc(1, C3, 1, 0, 0, 0,   0, 0, 0, "l3_x639_hs");
    cyc(1, C3, 0, 0, 0, 0,   0, 0, 0, "l4_x0");
    cyc(1, C3, 0, 0, 1, 639, 3, 3, 0, "l4_x1");
    cyc(1, C3, 0, 0, 0, 0,   0, 0, 0, "l4_x2");
    cyc(0, CN, 0, 0, 0, 0,   0, 0, 0, "l4_tail");
    cyc(0, CN, 0, 0, 1, 2,   4, 3, 0, "l4_flag");
    cyc(0, CN, 1, 0, 0, 0,   0, 0, 0, "l4_hs");

    // Line y=5: last flagged pixel, vsync rises the next cycle.
    cyc(1, C0, 0, 0, 0, 0, 0, 0, 0, "l5_x0");
    cyc(1, C0, 0, 0, 0, 0, 0, 0, 0, "l5_x1");
    cyc(1, C0, 0, 0, 0, 0, 0, 0, 0, "l5_x2");
    cyc(0, CN, 0, 1, 0, 0, 0, 0, 0, "vs_rise");
    cyc(0, CN, 0, 1, 1, 2, 5, 0, 0, "vs_b1");
    cyc(0, CN, 0, 1, 0, 0, 0, 0, 0, "vs_b2");
    cyc(0, CN, 1, 1, 0, 0, 0, 0, 1, "vs_b3_hs");
    cyc(0, CN, 0, 1, 0, 0, 0, 0, 1, "vs_b4");
    cyc(0, CN, 0, 0, 0, 0, 0, 0, 1, "vs_fall");
    cyc(1, C2, 0, 0, 0, 0, 0, 0, 1, "f2_x0");
    cyc(1, C2, 0, 0, 0, 0, 0, 0, 1, "f2_x1");
    cyc(1, C2, 0, 0, 0, 0, 0, 0, 0, "f2_x2");
    cyc(0, CN, 0, 0, 0, 0, 0, 0, 0, "f2_tail");
    cyc(0, CN, 0, 0, 1, 2, 0, 2, 0, "f2_flag");
    cyc(0, CN, 1, 0, 0, 0, 0, 0, 0, "f2_hs");

    // Line y=1 of this frame: run at x=98..102, reset while x=101 is reported.
    none_run(98, "l1b_lead");
    cyc(1, C1, 0, 0, 0, 0,   0, 0, 0, "l1b_x98");
    cyc(1, C1, 0, 0, 0, 0,   0, 0, 0, "l1b_x99");
    cyc(1, C1, 0, 0, 0, 0,   0, 0, 0, "l1b_x100");
    cyc(1, C1, 0, 0, 0, 0,   0, 0, 0, "l1b_x101");
    cyc(1, C1, 0, 0, 1, 100, 1, 1, 0, "l1b_x102");
    @(posedge clk);
    #1;
    chk("pre_reset.flag", 32'(interesting_flag), 1);
    chk("pre_reset.x", 32'(interesting_x), 101);
    reset = 1'b1;
    #1;
    chk("async_reset.flag", 32'(interesting_flag), 0);
    chk("async_reset.x", 32'(interesting_x), 0);
    chk("async_reset.y", 32'(interesting_y), 0);
    chk("async_reset.color", 32'(color), 0);
    chk("async_reset.frame_flag", 32'(frame_flag), 0);
    @(negedge clk);
    pixel_valid = 1'b0;
    drive_pixel(CN);
    hsync = 1'b0;
    vsync = 1'b0;
    @(negedge clk);
    reset = 1'b0;

    // After reset: nothing until a full vsync cycle has passed.
    repeat (5) cyc(1, C1, 0, 0, 0, 0, 0, 0, 0, "rst_sync");
    repeat (2) cyc(0, CN, 0, 0, 0, 0, 0, 0, 0, "rst_idle");
    cyc(0, CN, 1, 0, 0, 0, 0, 0, 0, "rst_hs");
    repeat (2) cyc(0, CN, 0, 1, 0, 0, 0, 0, 0, "rst_prime");
    cyc(0, CN, 0, 0, 0, 0, 0, 0, 0, "rst_fall");
    cyc(1, C1, 0, 0, 0, 0, 0, 0, 0, "rf_x0");
    cyc(1, C1, 0, 0, 0, 0, 0, 0, 0, "rf_x1");
    cyc(1, C1, 0, 0, 0, 0, 0, 0, 0, "rf_x2");
    cyc(0, CN, 0, 0, 0, 0, 0, 0, 0, "rf_tail");
    cyc(0, CN, 0, 0, 1, 2, 0, 1, 0, "rf_flag");
    cyc(0, CN, 0, 0, 0, 0, 0, 0, 0, "rf_end");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
